// File: rtl/request_unit_pkg.sv
// rtl/request_unit_pkg.sv - shared types and constants for the request unit
// Purpose: FSM state encoding, default ram address width, address checker.
// Ports: none (package).
package request_unit_pkg;

  localparam int RAM_AW = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DREQ = 2'd1,
    ST_IREQ = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // A word access is bad when it is not word aligned or reaches past the
  // aw-bit ram window.
  function automatic logic addr_bad(input logic [31:0] a, input int aw);
    return (a[1:0] != 2'b00) || ((a >> aw) != 32'd0);
  endfunction

endpackage

// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - ram-side bus between the request unit and the ram
// Purpose: groups the single-port ram handshake.
// Ports (signals): write_en, addr, data_in driven by the master (request unit);
//                  data_out, busy driven by the slave (ram).
interface request_unit_if #(
  parameter int AW = 12
) ();

  logic          write_en;
  logic [AW-1:0] addr;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          busy;

  modport master (output write_en, output addr, output data_in,
                  input  data_out, input  busy);

  modport slave  (input  write_en, input  addr, input  data_in,
                  output data_out, output busy);

endinterface

// File: rtl/request_unit.sv
// rtl/request_unit.sv - arbitrates fetch and data requests onto one ram port
// Purpose: accepts one fetch or data request at a time (data first), runs it
//          on the ram, then reports a one-cycle hit, with d_err on bad addresses.
// Ports: clk, rst (sync, active-high); i_ren/i_addr fetch request;
//        d_ren/d_wen/d_addr/d_wdata data request; instr/ihit, d_rdata/dhit,
//        d_err, stall responses; ram (master modport) to the ram.
module request_unit
  import request_unit_pkg::*;
#(
  parameter int RAM_AW = request_unit_pkg::RAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ren,
  input  logic [31:0]   i_addr,
  input  logic          d_ren,
  input  logic          d_wen,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   instr,
  output logic          ihit,
  output logic [31:0]   d_rdata,
  output logic          dhit,
  output logic          d_err,
  output logic          stall,
  request_unit_if.master ram
);

  state_e            state_q, state_d;
  logic              is_data_q, is_data_d;
  logic              is_write_q, is_write_d;
  logic              err_q, err_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              in_access;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_data_q  <= 1'b0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      instr_q    <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_data_q  <= is_data_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      instr_q    <= instr_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_data_d  = is_data_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    instr_d    = instr_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (d_ren || d_wen) begin
          is_data_d  = 1'b1;
          is_write_d = d_wen;
          addr_d     = d_addr[RAM_AW-1:0];
          wdata_d    = d_wdata;
          // Read-and-write at once is ambiguous, so it is rejected like a bad address.
          err_d      = addr_bad(d_addr, RAM_AW) || (d_ren && d_wen);
          state_d    = err_d ? ST_RESP : ST_DREQ;
        end else if (i_ren) begin
          is_data_d  = 1'b0;
          is_write_d = 1'b0;
          addr_d     = i_addr[RAM_AW-1:0];
          wdata_d    = '0;
          err_d      = addr_bad(i_addr, RAM_AW);
          state_d    = err_d ? ST_RESP : ST_IREQ;
        end
      end
      ST_DREQ, ST_IREQ: begin
        if (!ram.busy) begin
          if (state_q == ST_IREQ)  instr_d   = ram.data_out;
          else if (!is_write_q)    d_rdata_d = ram.data_out;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_access = (state_q == ST_DREQ) || (state_q == ST_IREQ);

  // rst gates write_en directly so a reset landing in DREQ never writes.
  assign ram.write_en = (state_q == ST_DREQ) && is_write_q && !rst;
  assign ram.addr     = in_access ? addr_q  : '0;
  assign ram.data_in  = in_access ? wdata_q : '0;

  assign ihit    = (state_q == ST_RESP) && !is_data_q;
  assign dhit    = (state_q == ST_RESP) &&  is_data_q;
  assign d_err   = (state_q == ST_RESP) &&  err_q;
  assign instr   = instr_q;
  assign d_rdata = d_rdata_q;
  assign stall   = (i_ren & ~ihit) | ((d_ren | d_wen) & ~dhit);

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed self-checking bench for request_unit
module tb_request_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ren, d_ren, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] instr, d_rdata;
  logic        ihit, dhit, d_err, stall;
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;

  request_unit_if #(.AW(12)) rif ();

  request_unit #(.RAM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .instr(instr), .ihit(ihit), .d_rdata(d_rdata), .dhit(dhit),
    .d_err(d_err), .stall(stall), .ram(rif)
  );

  always #5 clk = ~clk;

  // Ram model: combinational read, write on a rising edge when not busy.
  assign rif.data_out = mem[rif.addr[11:2]];
  always @(posedge clk) begin
    if (rif.write_en && !rif.busy) mem[rif.addr[11:2]] <= rif.data_in;
    if (rif.write_en) wr_cnt++;
    if (ihit && dhit) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_ren = 0; d_ren = 0; d_wen = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; rif.busy = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got %0h want 0", ihit); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL reset_dhit got %0h want 0", dhit); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset_derr got %0h want 0", d_err); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %08h want 0", instr); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h want 0", d_rdata); end
    checks++; if (rif.write_en !== 1'b0 || rif.addr !== 12'h0 || rif.data_in !== 32'h0) begin
      errors++; $display("FAIL reset_ram got we=%0h addr=%03h din=%08h want 0", rif.write_en, rif.addr, rif.data_in); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", stall); end
  endtask

  task automatic test_fetch();
    i_ren = 1'b1; i_addr = 32'h10; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_n got %0h want 1", stall); end
    step();
    checks++; if (ihit !== 1'b0 || rif.addr !== 12'h010 || rif.write_en !== 1'b0) begin
      errors++; $display("FAIL fetch_access got ihit=%0h addr=%03h we=%0h want 0/010/0", ihit, rif.addr, rif.write_en); end
    step();
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL fetch_hit got ihit=%0h dhit=%0h derr=%0h want 1/0/0", ihit, dhit, d_err); end
    checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL fetch_instr got %08h want 00500093", instr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_n2 got %0h want 0", stall); end
    i_ren = 1'b0;
    step();
    checks++; if (ihit !== 1'b0 || instr !== 32'h00500093) begin
      errors++; $display("FAIL fetch_hold got ihit=%0h instr=%08h want 0/00500093", ihit, instr); end
  endtask

  task automatic test_write_read();
    d_wen = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    step();
    checks++; if (rif.write_en !== 1'b1 || rif.addr !== 12'h020 || rif.data_in !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_access got we=%0h addr=%03h din=%08h want 1/020/deadbeef", rif.write_en, rif.addr, rif.data_in); end
    step();
    checks++; if (dhit !== 1'b1 || rif.write_en !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL wr_hit got dhit=%0h we=%0h derr=%0h want 1/0/0", dhit, rif.write_en, d_err); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_kept got %08h want 0", d_rdata); end
    d_wen = 1'b0;
    step();
    d_ren = 1'b1; d_addr = 32'h20;
    step(); step();
    checks++; if (dhit !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got dhit=%0h rdata=%08h want 1/deadbeef", dhit, d_rdata); end
    d_ren = 1'b0;
    step();
  endtask

  task automatic test_priority();
    i_ren = 1'b1; i_addr = 32'h10; d_ren = 1'b1; d_addr = 32'h20;
    step();
    checks++; if (rif.addr !== 12'h020) begin errors++; $display("FAIL prio_first got addr=%03h want 020", rif.addr); end
    step();
    checks++; if (dhit !== 1'b1 || ihit !== 1'b0) begin
      errors++; $display("FAIL prio_dhit got dhit=%0h ihit=%0h want 1/0", dhit, ihit); end
    d_ren = 1'b0;
    step(); step();
    checks++; if (rif.addr !== 12'h010 || ihit !== 1'b0) begin
      errors++; $display("FAIL prio_fetch_access got addr=%03h ihit=%0h want 010/0", rif.addr, ihit); end
    step();
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || instr !== 32'h00500093) begin
      errors++; $display("FAIL prio_ihit got ihit=%0h dhit=%0h instr=%08h want 1/0/00500093", ihit, dhit, instr); end
    i_ren = 1'b0;
    step();
  endtask

  task automatic test_busy();
    rif.busy = 1'b1; d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rif.write_en !== 1'b1 || rif.addr !== 12'h040 || dhit !== 1'b0) begin
        errors++; $display("FAIL busy_hold%0d got we=%0h addr=%03h dhit=%0h want 1/040/0", i, rif.write_en, rif.addr, dhit); end
      step();
    end
    rif.busy = 1'b0; #1;
    checks++; if (rif.write_en !== 1'b1 || dhit !== 1'b0) begin
      errors++; $display("FAIL busy_release got we=%0h dhit=%0h want 1/0", rif.write_en, dhit); end
    step();
    checks++; if (dhit !== 1'b1 || mem[16] !== 32'h12345678) begin
      errors++; $display("FAIL busy_hit got dhit=%0h mem=%08h want 1/12345678", dhit, mem[16]); end
    d_wen = 1'b0;
    step();
  endtask

  task automatic test_errors();
    int wr0;
    wr0 = wr_cnt;
    d_wen = 1'b1; d_addr = 32'h22; d_wdata = 32'h55AA55AA;
    step();
    checks++; if (dhit !== 1'b1 || d_err !== 1'b1 || rif.write_en !== 1'b0) begin
      errors++; $display("FAIL err_misalign got dhit=%0h derr=%0h we=%0h want 1/1/0", dhit, d_err, rif.write_en); end
    d_wen = 1'b0;
    step();
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0h want 0", d_err); end
    d_wen = 1'b1; d_addr = 32'h1000;
    step();
    checks++; if (dhit !== 1'b1 || d_err !== 1'b1) begin
      errors++; $display("FAIL err_range got dhit=%0h derr=%0h want 1/1", dhit, d_err); end
    d_wen = 1'b0;
    step();
    i_ren = 1'b1; i_addr = 32'h12;
    step();
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || d_err !== 1'b1) begin
      errors++; $display("FAIL err_fetch got ihit=%0h dhit=%0h derr=%0h want 1/0/1", ihit, dhit, d_err); end
    i_ren = 1'b0;
    step();
    checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL err_nowrite got %0d writes want %0d", wr_cnt, wr0); end
  endtask

  task automatic test_reset_mid();
    int wr0;
    d_wen = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    step();
    wr0 = wr_cnt;
    rst = 1'b1; d_wen = 1'b0; #1;
    checks++; if (rif.write_en !== 1'b0) begin errors++; $display("FAIL rstmid_gate got we=%0h want 0", rif.write_en); end
    step();
    rst = 1'b0; #1;
    checks++; if (ihit !== 1'b0 || dhit !== 1'b0 || d_err !== 1'b0 || instr !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_outs got ihit=%0h dhit=%0h derr=%0h instr=%08h rdata=%08h want 0", ihit, dhit, d_err, instr, d_rdata); end
    checks++; if (rif.write_en !== 1'b0 || rif.addr !== 12'h0 || rif.data_in !== 32'h0) begin
      errors++; $display("FAIL rstmid_ram got we=%0h addr=%03h din=%08h want 0", rif.write_en, rif.addr, rif.data_in); end
    step(); step();
    checks++; if (dhit !== 1'b0 || wr_cnt !== wr0 || mem[12] !== 32'h0) begin
      errors++; $display("FAIL rstmid_nowrite got dhit=%0h writes=%0d mem=%08h want 0/%0d/0", dhit, wr_cnt, mem[12], wr0); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    test_reset();
    test_fetch();
    test_write_read();
    test_priority();
    test_busy();
    test_errors();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL both_hits got %0d want 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, byte-address width of the ram port.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_ren input 1 (fetch request) and i_addr input 32 (fetch byte address).
REQ-005 SHALL have ports d_ren input 1, d_wen input 1, d_addr input 32 and d_wdata input 32 (data request).
REQ-006 SHALL have ports instr output 32, ihit output 1, d_rdata output 32, dhit output 1, d_err output 1 and stall output 1.
REQ-007 SHALL have ports write_en output 1, addr output RAM_AW and data_in output 32 (to ram), plus data_out input 32 and busy input 1 (from ram).

Function
REQ-008 SHALL implement FSM states IDLE, DREQ, IREQ and RESP.
REQ-009 IDLE, data request (d_ren|d_wen) present: SHALL latch d_addr, d_wdata and op, then go DREQ; data has priority over fetch.
REQ-010 IDLE, no data request, i_ren=1: SHALL latch i_addr and go IREQ.
REQ-011 IDLE with no request: SHALL stay IDLE and drive write_en=0, addr=0, data_in=0.
REQ-012 DREQ/IREQ: SHALL drive addr=latched addr[RAM_AW-1:0] and data_in=latched wdata; write_en=1 only in DREQ for a write.
REQ-013 DREQ/IREQ with busy=1: SHALL hold state and all ram-side outputs unchanged.
REQ-014 DREQ/IREQ with busy=0: SHALL register data_out into d_rdata (data read) or instr (fetch), then go RESP.
REQ-015 Data write: SHALL leave d_rdata unchanged.
REQ-016 RESP: SHALL assert exactly one of ihit/dhit for exactly one cycle, then return to IDLE; no request is captured in RESP.
REQ-017 Latency, busy=0: request seen in IDLE cycle N, ram access cycle N+1, hit cycle N+2, next capture cycle N+3.
REQ-018 Requesters SHALL deassert or change the request on the edge after the hit; a request still held in IDLE is a new access.
REQ-019 Error, data request: d_addr[1:0]!=0, any d_addr[31:RAM_AW]!=0, or d_ren&d_wen both 1: SHALL skip DREQ, go IDLE->RESP, and assert dhit and d_err together; no ram write occurs.
REQ-020 Error, fetch request: misaligned or out-of-range i_addr SHALL behave as REQ-019 but assert ihit with d_err.
REQ-021 d_err SHALL be 0 whenever no hit is asserted.
REQ-022 stall SHALL equal (i_ren & ~ihit) | ((d_ren|d_wen) & ~dhit), combinationally.
REQ-023 instr and d_rdata SHALL hold their last value until overwritten.

Reset
REQ-024 With rst=1 at a rising edge: state SHALL become IDLE; latched request, instr, d_rdata SHALL become 0; ihit, dhit, d_err SHALL become 0.
REQ-025 write_en SHALL be gated combinationally by ~rst, so no ram write occurs in a reset cycle, including reset asserted in DREQ.
REQ-026 A request in flight at reset SHALL be discarded without a hit; requesters re-issue after reset.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (2-bit) and the constant RAM_AW=12.
REQ-028 The block SHALL be one module with no sub-module; FSM, request latch and output registers are local.

Verification
REQ-029 Fetch: i_ren=1, i_addr=0x10, ram word 4 holds 0x00500093 -> ihit high exactly cycle N+2, instr=0x00500093, stall low from N+2.
REQ-030 Write then read: d_wen=1, d_addr=0x20, d_wdata=0xDEADBEEF -> write_en=1 one cycle with addr=0x020 and dhit at N+2; then d_ren=1, d_addr=0x20 -> d_rdata=0xDEADBEEF.
REQ-031 Priority: i_ren=1 and d_ren=1 both asserted in the same IDLE cycle -> data served first (dhit), fetch served next (ihit) 3 cycles later, never both hits in one cycle.
REQ-032 Busy: busy held high 3 cycles during DREQ -> addr/write_en stable throughout, dhit delayed exactly 3 cycles.
REQ-033 Errors: d_wen=1 with d_addr=0x22; then d_addr=0x1000 -> dhit and d_err high together, write_en never asserted.
REQ-034 Reset mid-op: rst pulsed in DREQ of a write to 0x30 -> no ram write, no hit, next cycle state IDLE and all outputs 0.
